// File: rtl/pe_mult_pipe.sv
// Two-stage pipelined multi-lane multiplier with valid/ready handshake.
// Optional accumulate mode is compiled in with PE_MULT_ACC_EN.
module pe_mult_pipe #(
    parameter int LANES  = 32,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic                      in_acc,
    input  logic [LANES*DATA_W-1:0]   mult_neuron,
    input  logic [LANES*DATA_W-1:0]   mult_weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*2*DATA_W-1:0] mult_result
);

    localparam int PW = 2 * DATA_W;

    logic                      adv_s2;
    logic                      adv_s1;

    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_signed_q, s1_signed_d;
    logic                      s1_acc_q, s1_acc_d;
    logic [LANES*DATA_W-1:0]   s1_neuron_q, s1_neuron_d;
    logic [LANES*DATA_W-1:0]   s1_weight_q, s1_weight_d;

    logic                      s2_valid_q, s2_valid_d;
    logic [LANES*PW-1:0]       s2_data_q, s2_data_d;

    logic [LANES*PW-1:0]       lane_result;
    logic [DATA_W-1:0]         op_a;
    logic [DATA_W-1:0]         op_b;
    logic [PW-1:0]             ext_a;
    logic [PW-1:0]             ext_b;
    logic [PW-1:0]             lane_prod;

    // Handshake: a stage may load when its downstream neighbour can take its beat.
    assign adv_s2   = !s2_valid_q || out_ready;
    assign adv_s1   = !s1_valid_q || adv_s2;
    assign in_ready = adv_s1;

    assign out_valid   = s2_valid_q;
    assign mult_result = s2_data_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_signed_d = s1_signed_q;
        s1_acc_d    = s1_acc_q;
        s1_neuron_d = s1_neuron_q;
        s1_weight_d = s1_weight_q;
        if (adv_s1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_signed_d = in_signed;
                s1_acc_d    = in_acc;
                s1_neuron_d = mult_neuron;
                s1_weight_d = mult_weight;
            end
        end
    end

    // Operands are extended to full product width so one multiply serves both signednesses.
    always_comb begin
        lane_result = '0;
        op_a        = '0;
        op_b        = '0;
        ext_a       = '0;
        ext_b       = '0;
        lane_prod   = '0;
        for (int i = 0; i < LANES; i++) begin
            op_a  = s1_neuron_q[DATA_W*(LANES-1-i) +: DATA_W];
            op_b  = s1_weight_q[DATA_W*(LANES-1-i) +: DATA_W];
            ext_a = s1_signed_q ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
            ext_b = s1_signed_q ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
            lane_prod = ext_a * ext_b;
`ifdef PE_MULT_ACC_EN
            if (s1_acc_q) begin
                lane_prod = lane_prod + s2_data_q[PW*i +: PW];
            end
`endif
            lane_result[PW*i +: PW] = lane_prod;
        end
    end

`ifndef PE_MULT_ACC_EN
    logic acc_unused;
    assign acc_unused = s1_acc_q;
`endif

    // Consumption without a new beat clears only the valid bit; the data register keeps its value.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (adv_s2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = lane_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_neuron_q <= '0;
            s1_weight_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_signed_q <= s1_signed_d;
            s1_acc_q    <= s1_acc_d;
            s1_neuron_q <= s1_neuron_d;
            s1_weight_q <= s1_weight_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
        end
    end

endmodule

// File: tb/tb_pe_mult_pipe.sv
// Self-checking bench for pe_mult_pipe with a lane-wise arithmetic reference model.
// Honours PE_MULT_ACC_EN the same way as the design.
module tb_pe_mult_pipe;

    localparam int L  = 32;
    localparam int W  = 16;
    localparam int NB = L * W;
    localparam int RB = 2 * L * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic          in_acc;
    logic [NB-1:0] mult_neuron;
    logic [NB-1:0] mult_weight;
    logic          out_valid;
    logic          out_ready;
    logic [RB-1:0] mult_result;

    int compared   = 0;
    int mismatched = 0;

    logic [RB-1:0] expQ[$];
    logic [RB-1:0] lastRes;

    always #5 clk = ~clk;

    pe_mult_pipe #(.LANES(L), .DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_acc      (in_acc),
        .mult_neuron (mult_neuron),
        .mult_weight (mult_weight),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .mult_result (mult_result)
    );

    // Reference: each lane is an ordinary integer product, optionally added to the previous result.
    function automatic logic [RB-1:0] modelBeat(input logic [NB-1:0] n, input logic [NB-1:0] w,
                                                input logic sgn, input logic acc);
        logic [RB-1:0]  r;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        longint         pa;
        longint         pb;
        longint         p;
        logic [2*W-1:0] lane;
        logic           accOn;
`ifdef PE_MULT_ACC_EN
        accOn = 1'b1;
`else
        accOn = 1'b0;
`endif
        r = '0;
        for (int i = 0; i < L; i++) begin
            a  = n[W*(L-1-i) +: W];
            b  = w[W*(L-1-i) +: W];
            pa = sgn ? longint'($signed(a)) : longint'(a);
            pb = sgn ? longint'($signed(b)) : longint'(b);
            p  = pa * pb;
            lane = p[2*W-1:0];
            if (acc && accOn) lane = lane + lastRes[2*W*i +: 2*W];
            r[2*W*i +: 2*W] = lane;
        end
        lastRes = r;
        return r;
    endfunction

    function automatic int firstDiffLane(input logic [RB-1:0] a, input logic [RB-1:0] b);
        for (int i = 0; i < L; i++) begin
            if (a[2*W*i +: 2*W] !== b[2*W*i +: 2*W]) return i;
        end
        return 0;
    endfunction

    function automatic logic [NB-1:0] lane0Vec(input logic [W-1:0] v);
        logic [NB-1:0] r;
        r = '0;
        r[NB-1 -: W] = v;
        return r;
    endfunction

    function automatic logic [NB-1:0] randVec();
        logic [NB-1:0] r;
        for (int i = 0; i < NB / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Drives one cycle of inputs at the falling edge and samples the outputs shortly after.
    task automatic driveCycle(input logic v, input logic sgn, input logic acc,
                              input logic [NB-1:0] n, input logic [NB-1:0] w, input logic ordy,
                              output logic accepted, output logic consumed,
                              output logic ovObs, output logic irObs, output logic [RB-1:0] res);
        @(negedge clk);
        in_valid    = v;
        in_signed   = sgn;
        in_acc      = acc;
        mult_neuron = n;
        mult_weight = w;
        out_ready   = ordy;
        #1;
        accepted = in_valid && in_ready;
        consumed = out_valid && out_ready;
        ovObs    = out_valid;
        irObs    = in_ready;
        res      = mult_result;
        if (accepted) expQ.push_back(modelBeat(n, w, sgn, acc));
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_acc = 1'b0;
        mult_neuron = '0; mult_weight = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        compared++;
        if (mult_result !== '0) begin mismatched++; $display("[TB] FAIL reset_result got nonzero want 0"); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        expQ.delete();
        lastRes = '0;
    endtask

    task automatic test_corner_products();
        logic [W-1:0]   nv[4]   = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
        logic [W-1:0]   wv[4]   = '{16'h8000, 16'h8000, 16'h0002, 16'h0002};
        logic           sv[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2*W-1:0] ev[4]   = '{32'h40000000, 32'h40000000, 32'hFFFFFFFE, 32'h0001FFFE};
        logic acc1, con, ov, ir;
        logic [RB-1:0] res, exp;
        for (int k = 0; k < 4; k++) begin
            driveCycle(1'b1, sv[k], 1'b0, lane0Vec(nv[k]), lane0Vec(wv[k]), 1'b1, acc1, con, ov, ir, res);
            compared++;
            if (acc1 !== 1'b1) begin mismatched++; $display("[TB] FAIL corner%0d_accept got %b want 1", k, acc1); end
            driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
            compared++;
            if (ov !== 1'b0) begin mismatched++; $display("[TB] FAIL corner%0d_early_valid got %b want 0", k, ov); end
            driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
            compared++;
            if (ov !== 1'b1) begin mismatched++; $display("[TB] FAIL corner%0d_latency got %b want 1", k, ov); end
            compared++;
            if (res[2*W-1:0] !== ev[k]) begin
                mismatched++; $display("[TB] FAIL corner%0d_lane0 got %h want %h", k, res[2*W-1:0], ev[k]);
            end
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                compared++;
                if (res !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL corner%0d_full lane %0d got %h want %h", k, firstDiffLane(res, exp),
                             res[2*W*firstDiffLane(res, exp) +: 2*W], exp[2*W*firstDiffLane(res, exp) +: 2*W]);
                end
            end
        end
    endtask

    task automatic test_lane_order();
        logic acc1, con, ov, ir;
        logic [RB-1:0] res, expL;
        logic [NB-1:0] n, w;
        n = '0; w = '0;
        n[W-1:0] = 16'd3;
        w[W-1:0] = 16'd5;
        expL = '0;
        expL[RB-1 -: 2*W] = 32'd15;
        driveCycle(1'b1, 1'b0, 1'b0, n, w, 1'b1, acc1, con, ov, ir, res);
        driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
        driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
        compared++;
        if (ov !== 1'b1 || res !== expL) begin
            mismatched++;
            $display("[TB] FAIL lane_order valid %b lane %0d got %h want %h", ov, firstDiffLane(res, expL),
                     res[2*W*firstDiffLane(res, expL) +: 2*W], expL[2*W*firstDiffLane(res, expL) +: 2*W]);
        end
        expQ.delete();
    endtask

    task automatic test_accumulate();
        logic [W-1:0]   an[3] = '{16'd2, 16'd4, 16'd1};
        logic [W-1:0]   aw[3] = '{16'd3, 16'd5, 16'd1};
        logic           aa[3] = '{1'b0, 1'b1, 1'b1};
`ifdef PE_MULT_ACC_EN
        logic [2*W-1:0] ev[3] = '{32'd6, 32'd26, 32'd27};
`else
        logic [2*W-1:0] ev[3] = '{32'd6, 32'd20, 32'd1};
`endif
        int sent = 0;
        int got  = 0;
        logic acc1, con, ov, ir;
        logic [RB-1:0] res, exp;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (sent < 3)
                driveCycle(1'b1, 1'b0, aa[sent], lane0Vec(an[sent]), lane0Vec(aw[sent]), 1'b1, acc1, con, ov, ir, res);
            else
                driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
            if (acc1) sent++;
            if (con) begin
                compared++;
                if (res[2*W-1:0] !== ev[got] || res[RB-1:2*W] !== '0) begin
                    mismatched++; $display("[TB] FAIL acc_beat%0d got %h want %h", got, res[2*W-1:0], ev[got]);
                end
                if (expQ.size() > 0) begin
                    exp = expQ.pop_front();
                    compared++;
                    if (res !== exp) begin
                        mismatched++; $display("[TB] FAIL acc_model%0d got %h want %h", got, res[2*W-1:0], exp[2*W-1:0]);
                    end
                end
                got++;
            end
        end
        compared++;
        if (got != 3) begin mismatched++; $display("[TB] FAIL acc_count got %0d want 3", got); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        logic ordy, acc1, con, ov, ir, haveStall;
        logic [RB-1:0] res, exp, stallRes;
        logic [NB-1:0] n, w;
        logic sgn;
        haveStall = 1'b0;
        stallRes  = '0;
        n = randVec(); w = randVec(); sgn = 1'($urandom);
        for (int c = 0; c < 60 && got < 8; c++) begin
            ordy = !(c >= 2 && c < 7);
            driveCycle(sent < 8, sgn, 1'b0, n, w, ordy, acc1, con, ov, ir, res);
            if (c == 2) begin
                compared++;
                if (ir !== 1'b0 || sent != 2) begin
                    mismatched++; $display("[TB] FAIL b2b_backpressure in_ready %b buffered %0d want 0 and 2", ir, sent);
                end
            end
            if (!ordy && ov) begin
                if (haveStall) begin
                    compared++;
                    if (res !== stallRes) begin
                        mismatched++; $display("[TB] FAIL b2b_hold lane0 got %h want %h", res[2*W-1:0], stallRes[2*W-1:0]);
                    end
                end
                haveStall = 1'b1;
                stallRes  = res;
            end
            if (acc1) begin
                sent++;
                n = randVec(); w = randVec(); sgn = 1'($urandom);
            end
            if (con) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++; $display("[TB] FAIL b2b_duplicate extra beat lane0 %h", res[2*W-1:0]);
                end else begin
                    exp = expQ.pop_front();
                    if (res !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL b2b_beat%0d lane %0d got %h want %h", got, firstDiffLane(res, exp),
                                 res[2*W*firstDiffLane(res, exp) +: 2*W], exp[2*W*firstDiffLane(res, exp) +: 2*W]);
                    end
                end
                got++;
            end
        end
        for (int c = 0; c < 3; c++) begin
            driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
            if (con) got++;
        end
        compared++;
        if (got != 8 || expQ.size() != 0) begin
            mismatched++; $display("[TB] FAIL b2b_count got %0d beats want 8 (pending %0d)", got, expQ.size());
        end
    endtask

    task automatic test_random();
        int got = 0;
        logic acc1, con, ov, ir;
        logic [RB-1:0] res, exp;
        for (int c = 0; c < 420; c++) begin
            if (c < 400)
                driveCycle(($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom), randVec(), randVec(),
                           ($urandom_range(9, 0) < 7), acc1, con, ov, ir, res);
            else
                driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
            if (con) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++; $display("[TB] FAIL rand_duplicate extra beat lane0 %h", res[2*W-1:0]);
                end else begin
                    exp = expQ.pop_front();
                    if (res !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL rand_beat%0d lane %0d got %h want %h", got, firstDiffLane(res, exp),
                                 res[2*W*firstDiffLane(res, exp) +: 2*W], exp[2*W*firstDiffLane(res, exp) +: 2*W]);
                    end
                end
                got++;
            end
        end
        compared++;
        if (expQ.size() != 0 || got == 0) begin
            mismatched++; $display("[TB] FAIL rand_drain pending %0d want 0 (received %0d)", expQ.size(), got);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc1, con, ov, ir;
        logic [RB-1:0] res;
        int stale = 0;
        driveCycle(1'b1, 1'b0, 1'b0, randVec(), randVec(), 1'b0, acc1, con, ov, ir, res);
        driveCycle(1'b1, 1'b1, 1'b0, randVec(), randVec(), 1'b0, acc1, con, ov, ir, res);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_out_valid got %b want 0", out_valid); end
        compared++;
        if (mult_result !== '0) begin mismatched++; $display("[TB] FAIL midrst_result got lane0 %h want 0", mult_result[2*W-1:0]); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
        expQ.delete();
        lastRes = '0;
        for (int c = 0; c < 5; c++) begin
            driveCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc1, con, ov, ir, res);
            if (ov) stale++;
        end
        compared++;
        if (stale != 0) begin mismatched++; $display("[TB] FAIL midrst_stale got %0d beats want 0", stale); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        lastRes = '0;
        test_reset();
        test_corner_products();
        test_lane_order();
        test_accumulate();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pe_mult_pipe.md
PE_MULT_PIPE -- requirements
Module: pe_mult_pipe

Interface
REQ-001 SHALL have parameter LANES, default 32: number of independent multiplier lanes.
REQ-002 SHALL have parameter DATA_W, default 16: operand width per lane; each product is 2*DATA_W bits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: the operand beat is valid.
REQ-006 SHALL have port in_ready  output  1: the block accepts a beat this cycle.
REQ-007 SHALL have port in_signed  input  1: 1 means two's-complement operands, 0 means unsigned; sampled with the beat.
REQ-008 SHALL have port in_acc  input  1: accumulate request, sampled with the beat; acted on only when PE_MULT_ACC_EN is defined.
REQ-009 SHALL have port mult_neuron  input  LANES*DATA_W: packed neuron operands.
REQ-010 SHALL have port mult_weight  input  LANES*DATA_W: packed weight operands.
REQ-011 SHALL have port out_valid  output  1: mult_result holds a valid beat.
REQ-012 SHALL have port out_ready  input  1: the consumer accepts the result beat.
REQ-013 SHALL have port mult_result  output  LANES*2*DATA_W: packed per-lane results.

Function
REQ-014 SHALL read operand lane i from bits [DATA_W*(LANES-1-i) +: DATA_W] (lane 0 in the MSBs) of mult_neuron and mult_weight.
REQ-015 SHALL drive result lane i on mult_result bits [2*DATA_W*i +: 2*DATA_W] (lane 0 in the LSBs).
REQ-016 SHALL compute each lane product at full 2*DATA_W width, signed or unsigned per the in_signed value captured with that beat; no truncation or saturation.
REQ-017 SHALL implement a two-stage pipeline: S1 registers the operands, in_signed and in_acc; S2 registers the results.
REQ-018 SHALL accept a beat when in_valid && in_ready; out_valid SHALL assert exactly 2 cycles after acceptance when out_ready stays high.
REQ-019 SHALL define advance S2 = !s2_valid || out_ready, advance S1 = !s1_valid || advance S2, and in_ready = advance S1 (combinational, no bubbles).
REQ-020 SHALL sustain one beat per cycle at full throughput when out_ready is held high.
REQ-021 SHALL hold mult_result and out_valid stable while out_valid && !out_ready; no beat SHALL be lost or duplicated.
REQ-022 SHALL clear only the valid bit of S2 on consumption, with no new beat entering; the S2 data register SHALL retain the last computed result.
REQ-023 SHALL load S1 and S2 in the same cycle when a beat is accepted and S1 advances simultaneously.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, clear s1_valid, s2_valid and all S1/S2 data registers to 0; out_valid=0 and mult_result=0 from the following cycle.
REQ-025 SHALL drop beats in flight when rst is asserted mid-transfer; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL use the macro PE_MULT_ACC_EN to compile in accumulate mode.
REQ-027 SHALL, with PE_MULT_ACC_EN defined, load S2 lane i with the product plus the current S2 data of lane i for any beat with in_acc=1, wrapping modulo 2^(2*DATA_W); beats with in_acc=0 SHALL load the plain product.
REQ-028 SHALL, with PE_MULT_ACC_EN undefined, ignore in_acc and contain no adder logic; every beat yields the plain product.

Verification
REQ-029 SHALL cover this case: LANES=32, DATA_W=16, signed beat with neuron lane0=0x8000, weight lane0=0x8000 -> mult_result[31:0]=0x40000000 exactly 2 cycles later.
REQ-030 SHALL cover this case: the same operands with in_signed=0 -> mult_result[31:0]=0x40000000; neuron lane0=0xFFFF, weight lane0=0x0002 -> signed 0xFFFFFFFE, unsigned 0x0001FFFE.
REQ-031 SHALL cover this case: 8 back-to-back beats with out_ready held low from beat 3 for 5 cycles -> in_ready falls after 2 beats are buffered, and all 8 results emerge in order with no loss or duplication.
REQ-032 SHALL cover this case: lane ordering with neuron lane31 (bits [15:0])=3, weight lane31=5, all other lanes 0 -> mult_result[1023:992]=15, and all other bits 0.
REQ-033 SHALL cover this case: rst asserted with 2 beats in flight -> out_valid=0 and mult_result=0 the next cycle, with no stale beat emitted afterwards.
REQ-034 SHALL cover this case: with PE_MULT_ACC_EN defined, beats (2*3, in_acc=0), (4*5, in_acc=1), (1*1, in_acc=1) on lane0 -> results 6, 26, 27; with the macro undefined -> results 6, 20, 1.
